ship_missile_ctrl: RTL



---
 rtl/space_pkg.sv | 36 +++
 rtl/slot_finder.sv | 27 ++
 rtl/ship_missile_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/space_pkg.sv
// space_pkg: definitions shared by the spaceship-game pipeline stages.
//   coord_t        10-bit unsigned screen coordinate
//   KEY_*          USB keycodes used by the game
//   SCREEN_*_MAX   last visible column/row of the 640x480 frame
//   spawn_x()      centres a missile on the ship nose, clamped to the screen
package space_pkg;

  typedef logic [9:0] coord_t;

  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_FIRE  = 8'h1A;
  localparam logic [7:0] KEY_START = 8'h2C;

  localparam coord_t SCREEN_X_MAX = 10'd639;
  localparam coord_t SCREEN_Y_MAX = 10'd479;

  // Missile left edge = ship centre minus half the missile width.
  // The sum is formed in 11 bits so a ship hanging off the right edge cannot
  // wrap; the result is clamped into 0..SCREEN_X_MAX.
  function automatic coord_t spawn_x(input coord_t ship_x,
                                     input coord_t ship_sx,
                                     input coord_t half_shot);
    logic [10:0] centre;
    centre = {1'b0, ship_x} + {2'b00, ship_sx[9:1]};
    if (centre < {1'b0, half_shot}) begin
      return '0;
    end
    centre = centre - {1'b0, half_shot};
    if (centre > {1'b0, SCREEN_X_MAX}) begin
      return SCREEN_X_MAX;
    end
    return centre[9:0];
  endfunction

endpackage

// File: rtl/slot_finder.sv
// slot_finder: combinational priority encoder returning the lowest index
// whose active bit is clear.
//   active    in   NUM_SHOTS  per-slot live flags (registered state)
//   free_idx  out  IDX_W      lowest free slot index (0 when none free)
//   found     out  1          at least one slot is free
module slot_finder #(
  parameter  int NUM_SHOTS = 4,
  localparam int IDX_W     = (NUM_SHOTS > 1) ? $clog2(NUM_SHOTS) : 1
) (
  input  logic [NUM_SHOTS-1:0] active,
  output logic [IDX_W-1:0]     free_idx,
  output logic                 found
);

  // Scan from the top down so the last hit (the lowest index) wins.
  always_comb begin
    free_idx = '0;
    found    = 1'b0;
    for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
      if (!active[i]) begin
        free_idx = IDX_W'(i);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ship_missile_ctrl.sv
// ship_missile_ctrl: missile manager behind the spaceship stage. Spawns up
// to NUM_SHOTS missiles at the ship nose on a fire key press and moves each
// one SHOT_STEP pixels up per frame until it leaves the top of the screen or
// the collision stage kills it.
//   frame_clk    in   1             frame-rate clock
//   Reset_n      in   1             asynchronous active-low reset
//   keycode      in   8             current USB keycode (W fires, Space clears)
//   ShipX/ShipY  in   10            ship left/top edge
//   ShipSX       in   10            ship width
//   kill_mask    in   NUM_SHOTS     bit i clears live slot i
//   ShotX/ShotY  out  10*NUM_SHOTS  packed per-slot edges, slot 0 in LSBs
//   ShotActive   out  NUM_SHOTS     per-slot live flags
//   ShotSX/SY    out  10            constant missile size
//   shots_fired  out  8             accepted fire count, wraps
// Build option: SHIP_MISSILE_AUTOFIRE_EN makes the fire key level-sensitive,
// so holding it fires every time the cooldown expires.
module ship_missile_ctrl
  import space_pkg::*;
#(
  parameter  int NUM_SHOTS = 4,
  parameter  int SHOT_STEP = 4,
  parameter  int COOLDOWN  = 8,
  parameter  int SHOT_SX   = 2,
  parameter  int SHOT_SY   = 6,
  parameter  int Y_MIN     = 0,
  localparam int IDX_W     = (NUM_SHOTS > 1) ? $clog2(NUM_SHOTS) : 1
) (
  input  logic                    frame_clk,
  input  logic                    Reset_n,
  input  logic [7:0]              keycode,
  input  logic [9:0]              ShipX,
  input  logic [9:0]              ShipY,
  input  logic [9:0]              ShipSX,
  input  logic [NUM_SHOTS-1:0]    kill_mask,
  output logic [10*NUM_SHOTS-1:0] ShotX,
  output logic [10*NUM_SHOTS-1:0] ShotY,
  output logic [NUM_SHOTS-1:0]    ShotActive,
  output logic [9:0]              ShotSX,
  output logic [9:0]              ShotSY,
  output logic [7:0]              shots_fired
);

  localparam coord_t SHOT_SX_C   = coord_t'(SHOT_SX);
  localparam coord_t SHOT_SY_C   = coord_t'(SHOT_SY);
  localparam coord_t HALF_SHOT   = coord_t'(SHOT_SX / 2);
  localparam coord_t STEP_C      = coord_t'(SHOT_STEP);
  // Any shot above this row would cross Y_MIN on its next step.
  localparam coord_t EXIT_Y      = coord_t'(Y_MIN + SHOT_STEP);
  localparam logic [7:0] COOLDOWN_C = 8'(COOLDOWN);

  logic       fire_prev_reg;
  logic [7:0] cooldown_reg, cooldown_next;
  logic [7:0] shots_fired_reg, shots_fired_next;

  logic             fire_key;
  logic             start_key;
  logic             fire_req;
  logic             accept;
  logic [IDX_W-1:0] free_idx;
  logic             free_found;
  coord_t           spawn_x_val;
  coord_t           spawn_y_val;

  assign fire_key  = (keycode == KEY_FIRE);
  assign start_key = (keycode == KEY_START);

`ifdef SHIP_MISSILE_AUTOFIRE_EN
  assign fire_req = fire_key;
`else
  assign fire_req = fire_key & ~fire_prev_reg;
`endif

  // Slot choice uses only registered flags, so a slot killed this frame
  // cannot be refilled until the following frame.
  slot_finder #(
    .NUM_SHOTS (NUM_SHOTS)
  ) u_slot_finder (
    .active   (ShotActive),
    .free_idx (free_idx),
    .found    (free_found)
  );

  // A rejected request is simply dropped; nothing is queued for later.
  assign accept = fire_req && !start_key && (cooldown_reg == 8'd0) &&
                  free_found && (ShipY >= SHOT_SY_C);

  assign spawn_x_val = spawn_x(ShipX, ShipSX, HALF_SHOT);
  assign spawn_y_val = ShipY - SHOT_SY_C;

  always_comb begin
    cooldown_next    = cooldown_reg;
    shots_fired_next = shots_fired_reg;
    if (start_key) begin
      cooldown_next = 8'd0;
    end else if (accept) begin
      cooldown_next    = COOLDOWN_C;
      shots_fired_next = shots_fired_reg + 8'd1;
    end else if (cooldown_reg != 8'd0) begin
      cooldown_next = cooldown_reg - 8'd1;
    end
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fire_prev_reg   <= 1'b0;
      cooldown_reg    <= 8'd0;
      shots_fired_reg <= 8'd0;
    end else begin
      fire_prev_reg   <= fire_key;
      cooldown_reg    <= cooldown_next;
      shots_fired_reg <= shots_fired_next;
    end
  end

  assign shots_fired = shots_fired_reg;
  assign ShotSX      = SHOT_SX_C;
  assign ShotSY      = SHOT_SY_C;

  generate
    for (genvar gi = 0; gi < NUM_SHOTS; gi++) begin : g_slot
      logic   active_reg, active_next;
      coord_t x_reg, x_next;
      coord_t y_reg, y_next;

      // Start wins over spawn, spawn only targets a free slot, and an
      // in-flight shot is killed, exits, or climbs in that order.
      always_comb begin
        active_next = active_reg;
        x_next      = x_reg;
        y_next      = y_reg;
        if (start_key) begin
          active_next = 1'b0;
        end else if (accept && (free_idx == IDX_W'(gi))) begin
          active_next = 1'b1;
          x_next      = spawn_x_val;
          y_next      = spawn_y_val;
        end else if (active_reg) begin
          if (kill_mask[gi]) begin
            active_next = 1'b0;
          end else if (y_reg < EXIT_Y) begin
            active_next = 1'b0;
          end else begin
            y_next = y_reg - STEP_C;
          end
        end
      end

      always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
          active_reg <= 1'b0;
          x_reg      <= '0;
          y_reg      <= '0;
        end else begin
          active_reg <= active_next;
          x_reg      <= x_next;
          y_reg      <= y_next;
        end
      end

      assign ShotActive[gi]     = active_reg;
      assign ShotX[gi*10 +: 10] = x_reg;
      assign ShotY[gi*10 +: 10] = y_reg;
    end
  endgenerate

endmodule
